linear_interpolator: RTL and testbench

//  Interpolating upsampler: the complement of the decimating moving-average block.
//  - Accepts one BITS_ADC sample per rdy_in strobe.
//  - Emits DF = 2^k output samples per input, one per output-rate tick.
//  - Each segment ramps linearly from the previous sample to the new one.
//  - Sits between a low-rate sample source and a higher-rate consumer (display/DAC path).

---
 rtl/linear_interpolator.sv | 118 +++++++++++
 tb/tb_linear_interpolator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/linear_interpolator.sv
// Interpolating upsampler: each accepted sample becomes 2^k output samples that
// ramp from the previous sample. Define LINEAR_INTERP_EN for the linear ramp; otherwise zero-order hold.
module linear_interpolator #(
    parameter  int BITS_ADC  = 8,
    parameter  int BITS_ACUM = 12,
    localparam int K_MAX     = BITS_ACUM - BITS_ADC,
    localparam int KW        = $clog2(K_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KW-1:0]       k,
    input  logic [BITS_ADC-1:0] sample_in,
    input  logic                rdy_in,
    output logic                ready_in,
    input  logic                tick,
    output logic [BITS_ADC-1:0] sample_out,
    output logic                rdy_out,
    output logic                overrun,
    output logic [1:0]          state_dbg
);
    // Handshake: a sample is taken on any edge where rdy_in=1 and ready_in=1;
    // rdy_in while ready_in=0 is dropped and sets the sticky overrun flag.
    // rdy_out is a 1-cycle strobe qualifying sample_out.

    localparam int ACW = BITS_ACUM + 1;
    localparam int DW  = BITS_ADC + 1;
    localparam int CW  = K_MAX + 1;

    typedef enum logic [1:0] {EMPTY = 2'd0, IDLE = 2'd1, RUN = 2'd2} state_t;

    state_t              state, state_nxt;
    logic [ACW-1:0]      acc;
    logic [DW-1:0]       delta;
    logic [CW-1:0]       count;
    logic [KW-1:0]       kk;

    logic                accept, drop, fire;
    logic [KW-1:0]       kk_new;
    logic [BITS_ADC-1:0] prev_new;
    logic [ACW-1:0]      acc_new, acc_sh;
    logic [DW-1:0]       delta_new;

`ifdef LINEAR_INTERP_EN
    logic [BITS_ADC-1:0] last_smp;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY, IDLE: if (rdy_in) state_nxt = RUN;
            RUN:         if (tick && count == CW'(1)) state_nxt = IDLE;
            default:     state_nxt = EMPTY;
        endcase
    end

    // Control decode and accept-time datapath values
    always_comb begin
        accept   = rdy_in && (state != RUN);
        drop     = rdy_in && (state == RUN);
        fire     = tick && (state == RUN);
        kk_new   = (k > KW'(K_MAX)) ? KW'(K_MAX) : k;
`ifdef LINEAR_INTERP_EN
        prev_new = (state == EMPTY) ? sample_in : last_smp;
`else
        prev_new = sample_in;
`endif
        acc_new   = {{(ACW - BITS_ADC){1'b0}}, prev_new} << kk_new;
        delta_new = {1'b0, sample_in} - {1'b0, prev_new};
        acc_sh    = acc >> kk;
    end

    assign state_dbg = state;

    // Datapath and registered outputs; acc stays non-negative, so a logical
    // shift gives the floor of the ramp value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            delta      <= '0;
            count      <= '0;
            kk         <= '0;
            sample_out <= '0;
            rdy_out    <= 1'b0;
            ready_in   <= 1'b1;
            overrun    <= 1'b0;
        end else begin
            rdy_out  <= 1'b0;
            ready_in <= (state_nxt != RUN);
            if (drop) overrun <= 1'b1;
            if (accept) begin
                kk    <= kk_new;
                count <= CW'(1) << kk_new;
                acc   <= acc_new;
                delta <= delta_new;
            end else if (fire) begin
                sample_out <= acc_sh[BITS_ADC-1:0];
                rdy_out    <= 1'b1;
                acc        <= acc + {{(ACW - DW){delta[DW-1]}}, delta};
                count      <= count - CW'(1);
            end
        end
    end

`ifdef LINEAR_INTERP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        last_smp <= '0;
        else if (accept) last_smp <= sample_in;
    end
`endif

endmodule

// File: tb/tb_linear_interpolator.sv
// Randomized scoreboard bench for linear_interpolator; the reference model follows
// the LINEAR_INTERP_EN build option of the design.
module tb_linear_interpolator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] k = '0;
    logic [7:0] sample_in = '0;
    logic       rdy_in = 1'b0;
    logic       ready_in;
    logic       tick = 1'b0;
    logic [7:0] sample_out;
    logic       rdy_out;
    logic       overrun;
    logic [1:0] state_dbg;

    logic [7:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int n_out = 0;
    bit tick_en = 1'b0;
    int tick_gap = 3;
    int tcnt = 0;
    bit m_empty = 1'b1;
    int m_prev = 0;

    linear_interpolator dut (
        .clk(clk), .rst(rst), .k(k), .sample_in(sample_in), .rdy_in(rdy_in),
        .ready_in(ready_in), .tick(tick), .sample_out(sample_out), .rdy_out(rdy_out),
        .overrun(overrun), .state_dbg(state_dbg)
    );

    // Clock and tick generation
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (tick_en && tcnt == 0) begin
                tick = 1'b1;
                tcnt = tick_gap - 1;
            end else begin
                tick = 1'b0;
                if (tcnt > 0) tcnt--;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: output j of a segment is prev + floor(j*(cur-prev)/DF)
    function automatic int ramp_val(input int prev, input int cur, input int j, input int df);
        int num, q;
        num = j * (cur - prev);
        q = num / df;
        if (num < 0 && (num % df) != 0) q = q - 1;
        return prev + q;
    endfunction

    task automatic model_accept(input int s, input int kv);
        int kk, df, prev;
        kk = (kv > 4) ? 4 : kv;
        df = 1 << kk;
`ifdef LINEAR_INTERP_EN
        prev = m_empty ? s : m_prev;
`else
        prev = s;
`endif
        for (int j = 0; j < df; j++) exp_q.push_back(8'(ramp_val(prev, s, j, df)));
        m_prev = s;
        m_empty = 1'b0;
    endtask

    // Driver: wait for ready_in, present one sample for one cycle
    task automatic send(input int s, input int kv);
        int n = 0;
        while (!ready_in && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!ready_in) begin
            chk("send_timeout", 0, 1);
            return;
        end
        k = 3'(kv);
        sample_in = 8'(s);
        rdy_in = 1'b1;
        model_accept(s, kv);
        @(negedge clk);
        rdy_in = 1'b0;
        chk("ready_drop", int'(ready_in), 0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
        @(negedge clk);
        chk("drain_ready", int'(ready_in), 1);
    endtask

    task automatic pulse_drop(input int s);
        sample_in = 8'(s);
        rdy_in = 1'b1;
        @(negedge clk);
        rdy_in = 1'b0;
    endtask

    // Monitor: every rdy_out must match the head of the expected queue
    initial begin
        forever begin
            @(negedge clk);
            if (rst && rdy_out) begin
                n_out++;
                if (exp_q.size() == 0) chk("unexpected_output", int'(sample_out), -1);
                else chk("sample_out", int'(sample_out), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #3_000_000;
        chk("global_timeout", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int base, n;
        // Reset values and ticks in EMPTY
        #12;
        chk("rst_sample_out", int'(sample_out), 0);
        chk("rst_rdy_out", int'(rdy_out), 0);
        chk("rst_ready_in", int'(ready_in), 1);
        chk("rst_overrun", int'(overrun), 0);
        @(negedge clk);
        rst = 1'b1;
        tick_gap = 1;
        tick_en = 1'b1;
        repeat (12) @(negedge clk);
        chk("empty_ticks_out", n_out, 0);

        // Ramp 100 -> 140 with k=2, ticks every 3 clocks
        tick_gap = 3;
        send(100, 2);
        send(140, 2);
        drain();

        // Descending ramp with k=3
        send(200, 3);
        send(120, 3);
        drain();

        // Ticks while IDLE produce nothing
        base = n_out;
        repeat (10) @(negedge clk);
        chk("idle_ticks_out", n_out - base, 0);

        // k=0 passes samples through
        send(5, 0);
        send(250, 0);
        send(0, 0);
        drain();

        // Input during RUN is dropped and sets sticky overrun
        send(30, 2);
        repeat (2) @(negedge clk);
        chk("busy_ready_in", int'(ready_in), 0);
        pulse_drop(77);
        chk("overrun_set", int'(overrun), 1);
        drain();
        chk("overrun_sticky", int'(overrun), 1);

        // k above the maximum clamps to 16 outputs
        tick_gap = 1;
        base = n_out;
        send(10, 7);
        send(250, 7);
        drain();
        chk("clamp_count", n_out - base, 32);

        // Reset mid-segment, then the next sample starts fresh
        tick_gap = 3;
        send(100, 2);
        send(140, 2);
        n = 0;
        while (exp_q.size() > 2 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid_seg_reach", exp_q.size(), 2);
        rst = 1'b0;
        #1;
        chk("midrst_sample_out", int'(sample_out), 0);
        chk("midrst_rdy_out", int'(rdy_out), 0);
        chk("midrst_ready_in", int'(ready_in), 1);
        chk("midrst_overrun", int'(overrun), 0);
        exp_q.delete();
        m_empty = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        base = n_out;
        send(60, 2);
        drain();
        chk("after_rst_count", n_out - base, 4);

        // Randomized segments with k changes during RUN and occasional drops
        for (int i = 0; i < 40; i++) begin
            tick_gap = $urandom_range(1, 4);
            send($urandom_range(0, 255), $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) k = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0 && !ready_in) pulse_drop($urandom_range(0, 255));
        end
        drain();

        tick_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
